memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Arbitrates between the instruction cache and the data cache for a single-ported RAM and steps one word access at a time through a registered grant state machine. Sits directly downstream of the dcache and icache: it consumes the dcache write-back and allocate word requests and returns load data with a wait handshake. Data-cache requests have priority. An optional block lock keeps the two word accesses of one dcache block transfer back to back.

## Interface
- TIMEOUT, 255: cycles a granted access may wait for RAM ACCESS before it is force-completed as an error (8-bit counter).
- LOCK_WINDOW, 4: cycles the dcache lock is held open waiting for the second word (only with DBURST_LOCK_EN).
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iload  out  32  instruction read data
- iwait  out  1  low for exactly the completing cycle of an icache access
- dREN, dWEN  in  1 each  dcache read / write request
- daddr  in  32  dcache word address; bit 2 = block offset
- dstore  in  32  dcache write data
- dload  out  32  data read data
- dwait  out  1  low for exactly the completing cycle of a dcache access
- ramREN, ramWEN  out  1 each  RAM read / write strobe
- ramaddr, ramstore  out  32 each  RAM address / write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- merr  out  1  sticky error flag, cleared only by reset

## Operation
- States: IDLE, IGNT, DGNT, and DLOCK (DLOCK exists only with the macro).
- IDLE:
  - dcache request (dREN|dWEN) -> DGNT.
  - Else iREN -> IGNT.
  - Else stay in IDLE.
  - When both request, dcache wins; icache keeps waiting.
- DGNT: ramaddr=daddr.
  - dWEN -> ramWEN=1, ramstore=dstore.
  - Else ramREN=1.
  - dREN and dWEN both high: dWEN wins.
- IGNT: ramREN=1, ramaddr=iaddr.
- Completion, in the granted state when ramstate==ACCESS:
  - The granted side's wait goes low combinationally that cycle.
  - Its load = ramload (dload is don't-care on writes; drive ramload).
  - Next state is IDLE, or DLOCK per Configuration.
- Ungranted side: wait=1, load=0.
- ramstate==ERROR while granted: complete as above, load=32'hBAD1BAD1, merr<=1.
- Timeout: an 8-bit counter clears on each grant and increments each granted cycle without ACCESS. At TIMEOUT, complete with load=32'hBAD1BAD1 and set merr.
- Abandon: if the granted side drops all its request strobes before completion:
  - RAM strobes deassert that cycle.
  - No wait-low pulse is produced.
  - Next state is IDLE.
- Requesters hold addr and data stable while wait=1. The arbiter does not latch them.
- Reset, asynchronous, any state including mid-access:
  - State=IDLE, counters=0, merr=0.
  - iwait=dwait=1, iload=dload=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.

## Timing
- Grant is registered: a request seen in IDLE on edge N drives the RAM strobes from cycle N+1.
- Minimum latency, request to wait-low: 2 cycles (IDLE, then a granted cycle with ACCESS).
- Back-to-back accesses to the same side: one IDLE cycle between them, unless DLOCK applies.
- Wait-low is a one-cycle pulse. A cache advancing its own FSM on that cycle sees a new grant no earlier than 2 cycles later.
- With DBURST_LOCK_EN, a dcache two-word block transfer takes 4 + 2×(RAM wait) cycles with no icache interleave.

## Configuration
- DBURST_LOCK_EN defined:
  - Completing a dcache access with daddr[2]==0 enters DLOCK.
  - In DLOCK, a dcache request with daddr[2]==1 and daddr[31:3] equal to the locked block -> DGNT, regardless of iREN.
  - DLOCK -> IDLE after LOCK_WINDOW cycles with no matching request, or on any non-matching dcache request.
- DBURST_LOCK_EN undefined: DLOCK is absent; after any completion the next state is IDLE, with plain dcache priority.

## Structure
- Shared package cpu_types_pkg:
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR).
  - arb_state_t enum.
  - word_t.
  - constant BAD_DATA=32'hBAD1BAD1.
- One sub-module, arb_timeout_ctr: 8-bit counter with clear, enable and hit-at-TIMEOUT output. It is instantiated once for the timeout and reused for LOCK_WINDOW.
- The remainder is one registered FSM plus combinational output muxing.

## Test plan
- dREN=1, daddr=0x40, ramstate ACCESS on the 3rd granted cycle, ramload=0x12345678 -> ramREN from cycle 1; dwait low exactly one cycle, 4 cycles after the request; dload=0x12345678.
- iREN and dWEN asserted together, daddr=0x80, dstore=0xCAFEF00D -> ramWEN=1, ramaddr=0x80 first; iwait stays high; the icache read is granted after the write completes plus one IDLE cycle.
- With DBURST_LOCK_EN: dREN 0x100, then dREN 0x104 while iREN is held -> both dcache words complete before ramREN is driven with iaddr. Without the macro, the icache is granted between them.
- ramstate held BUSY -> completion at TIMEOUT=255 granted cycles, dload=0xBAD1BAD1, merr=1 until reset.
- iREN dropped mid-access -> ramREN=0 that cycle, no iwait pulse, state IDLE next cycle.
- nRST asserted mid-DGNT -> all outputs return to reset values immediately, asynchronously; a new dREN after release is granted normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the memory arbiter.
// The DLOCK state exists only when DBURST_LOCK_EN is defined.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
`ifdef DBURST_LOCK_EN
    ,
    DLOCK = 2'd3
`endif
  } arb_state_t;

  localparam word_t      BAD_DATA    = 32'hBAD1BAD1;
  localparam logic [7:0] TIMEOUT     = 8'd255;
  localparam logic [7:0] LOCK_WINDOW = 8'd4;

endpackage

// File: rtl/arb_timeout_ctr.sv
// 8-bit cycle counter. hit flags the cycle in which the limit-th enabled
// cycle since the last clear is being counted.
module arb_timeout_ctr (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       hit
);

  logic [7:0] count;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)      count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + 8'd1;
  end

  assign hit = ((count + 8'd1) == limit);

endmodule

// File: rtl/memory_arbiter.sv
// icache/dcache arbiter for a single-ported RAM, dcache has priority.
// Define DBURST_LOCK_EN to keep both words of a dcache block back to back.
module memory_arbiter
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       iREN,
  input  word_t      iaddr,
  output word_t      iload,
  output logic       iwait,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output word_t      dload,
  output logic       dwait,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic [1:0] ramstate,
  output logic       merr,
  output arb_state_t dbg_state
);

  // Handshake: a requester raises its strobe(s) and holds address/data
  // stable while its wait is high; wait low for one cycle marks completion,
  // dropping the strobes before that abandons the access with no pulse.

  arb_state_t state, next_state;
  ramstate_t  rs;
  logic       dreq, cnt_hit, done, err, merr_set;
  logic [7:0] cnt_limit;

  assign rs        = ramstate_t'(ramstate);
  assign dreq      = dREN | dWEN;
  assign done      = (rs == ACCESS) || (rs == ERROR) || cnt_hit;
  assign err       = (rs != ACCESS);
  assign dbg_state = state;

`ifdef DBURST_LOCK_EN
  logic [28:0] lock_blk;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)                                     lock_blk <= '0;
    else if (state == DGNT && next_state == DLOCK) lock_blk <= daddr[31:3];
  end

  assign cnt_limit = (state == DLOCK) ? LOCK_WINDOW : TIMEOUT;
`else
  assign cnt_limit = TIMEOUT;
`endif

  // One counter serves both the access timeout and the lock window.
  arb_timeout_ctr u_ctr (
    .CLK   (CLK),
    .nRST  (nRST),
    .clear (next_state != state),
    .en    (1'b1),
    .limit (cnt_limit),
    .hit   (cnt_hit)
  );

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)         merr <= 1'b0;
    else if (merr_set) merr <= 1'b1;
  end

  always_comb begin
    next_state = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    merr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (dreq)      next_state = DGNT;
        else if (iREN) next_state = IGNT;
      end
      IGNT: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          iload   = ramload;
          if (done) begin
            iwait      = 1'b0;
            next_state = IDLE;
            if (err) begin
              iload    = BAD_DATA;
              merr_set = 1'b1;
            end
          end
        end
      end
      DGNT: begin
        if (!dreq) begin
          next_state = IDLE;
        end else begin
          ramaddr = daddr;
          dload   = ramload;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (done) begin
            dwait      = 1'b0;
            next_state = IDLE;
`ifdef DBURST_LOCK_EN
            if (!daddr[2]) next_state = DLOCK;
`endif
            if (err) begin
              dload    = BAD_DATA;
              merr_set = 1'b1;
            end
          end
        end
      end
`ifdef DBURST_LOCK_EN
      DLOCK: begin
        // Only the odd word of the locked block may claim the RAM here.
        if (dreq) begin
          if (daddr[2] && (daddr[31:3] == lock_blk)) next_state = DGNT;
          else                                       next_state = IDLE;
        end else if (cnt_hit) begin
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random
// traffic checked every cycle against a transaction-level model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int TO_CYC   = 255;
  localparam int LOCK_CYC = 4;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;
`ifdef DBURST_LOCK_EN
  localparam int IGAP = 5;
`else
  localparam int IGAP = 1;
`endif

  logic       CLK = 1'b0;
  logic       nRST;
  logic       iREN, dREN, dWEN;
  word_t      iaddr, daddr, dstore, ramload;
  logic [1:0] ramstate;
  word_t      iload, dload, ramaddr, ramstore;
  logic       iwait, dwait, ramREN, ramWEN, merr;
  arb_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  memory_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    end
  endtask

  // ---------------- reference model ----------------
  // owner: 0 nobody, 1 icache access, 2 dcache access, 3 lock window open
  int          m_owner, m_waited, m_lock_left;
  logic [28:0] m_lock_blk;
  logic        m_merr, m_i_done, m_d_done;
  logic        e_ren, e_wen, e_iwait, e_dwait, ck_il, ck_dl, m_dreq, m_done, m_err;
  word_t       e_addr, e_store, e_iload, e_dload;

  initial begin
    m_owner = 0; m_waited = 0; m_lock_left = 0; m_lock_blk = '0;
    m_merr = 1'b0; m_i_done = 1'b0; m_d_done = 1'b0;
  end

  always @(negedge CLK) begin
    m_i_done = 1'b0;
    m_d_done = 1'b0;
    if (!nRST) begin
      chk("rst_iwait", iwait, 1);   chk("rst_dwait", dwait, 1);
      chk("rst_iload", iload, 0);   chk("rst_dload", dload, 0);
      chk("rst_ramREN", ramREN, 0); chk("rst_ramWEN", ramWEN, 0);
      chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);
      chk("rst_merr", merr, 0);
      m_owner = 0; m_waited = 0; m_merr = 1'b0;
    end else begin
      chk("merr", merr, m_merr);
      m_dreq = dREN | dWEN;
      m_done = (ramstate == 2'd2) || (ramstate == 2'd3) || (m_waited + 1 == TO_CYC);
      m_err  = (ramstate != 2'd2);
      e_ren = 1'b0; e_wen = 1'b0; e_iwait = 1'b1; e_dwait = 1'b1;
      e_iload = '0; e_dload = '0; ck_il = 1'b1; ck_dl = 1'b1;
      e_addr = '0; e_store = '0;
      if (m_owner == 1) begin
        ck_il = 1'b0;
        if (iREN) begin
          e_ren = 1'b1; e_addr = iaddr;
          if (m_done) begin
            e_iwait = 1'b0; ck_il = 1'b1;
            e_iload = m_err ? BAD : ramload;
          end
        end
      end else if (m_owner == 2) begin
        ck_dl = 1'b0;
        if (m_dreq) begin
          e_addr = daddr;
          if (dWEN) begin e_wen = 1'b1; e_store = dstore; end
          else e_ren = 1'b1;
          if (m_done) begin
            e_dwait = 1'b0; ck_dl = 1'b1;
            e_dload = m_err ? BAD : ramload;
          end
        end
      end
      chk("ramREN", ramREN, e_ren);
      chk("ramWEN", ramWEN, e_wen);
      chk("iwait", iwait, e_iwait);
      chk("dwait", dwait, e_dwait);
      if (e_ren || e_wen) chk("ramaddr", ramaddr, e_addr);
      if (e_wen)          chk("ramstore", ramstore, e_store);
      if (ck_il)          chk("iload", iload, e_iload);
      if (ck_dl)          chk("dload", dload, e_dload);

      case (m_owner)
        0: begin
          if (m_dreq)    begin m_owner = 2; m_waited = 0; end
          else if (iREN) begin m_owner = 1; m_waited = 0; end
        end
        1: begin
          if (!iREN) m_owner = 0;
          else if (m_done) begin
            m_owner = 0; m_i_done = 1'b1;
            if (m_err) m_merr = 1'b1;
          end else m_waited++;
        end
        2: begin
          if (!m_dreq) m_owner = 0;
          else if (m_done) begin
            m_owner = 0; m_d_done = 1'b1;
            if (m_err) m_merr = 1'b1;
`ifdef DBURST_LOCK_EN
            if (!daddr[2]) begin
              m_owner = 3; m_lock_blk = daddr[31:3]; m_lock_left = LOCK_CYC;
            end
`endif
          end else m_waited++;
        end
        default: begin
          if (m_dreq) begin
            if (daddr[2] && daddr[31:3] == m_lock_blk) begin m_owner = 2; m_waited = 0; end
            else m_owner = 0;
          end else begin
            m_lock_left--;
            if (m_lock_left == 0) m_owner = 0;
          end
        end
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic        seen, d_act, i_act, d_follow, dw, iw;
  int          gcnt, phase;
  logic [31:0] got;

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_iwait", iwait, 1); chk("reset_dwait", dwait, 1);
    chk("reset_ramREN", ramREN, 0); chk("reset_merr", merr, 0);
    tick(); nRST = 1'b1;

    // Read 0x40, ACCESS on the third granted cycle
    tick(); dREN = 1'b1; daddr = 32'h40; ramstate = BUSY;
    @(negedge CLK); chk("t1_c0_ren", ramREN, 0); chk("t1_c0_dwait", dwait, 1);
    tick();
    @(negedge CLK); chk("t1_c1_ren", ramREN, 1); chk("t1_c1_addr", ramaddr, 32'h40);
    chk("t1_c1_dwait", dwait, 1);
    tick();
    @(negedge CLK); chk("t1_c2_dwait", dwait, 1);
    tick(); ramstate = ACCESS; ramload = 32'h12345678;
    @(negedge CLK); chk("t1_c3_dwait", dwait, 0); chk("t1_c3_dload", dload, 32'h12345678);
    tick(); dREN = 1'b0; ramstate = FREE;
    @(negedge CLK); chk("t1_c4_dwait", dwait, 1); chk("t1_c4_ren", ramREN, 0);
    settle(6);

    // Simultaneous write and instruction fetch
    tick(); iREN = 1'b1; iaddr = 32'h200; dWEN = 1'b1; daddr = 32'h80;
    dstore = 32'hCAFEF00D; ramstate = ACCESS; ramload = 32'h11112222;
    @(negedge CLK); chk("t2_c0_wen", ramWEN, 0);
    tick();
    @(negedge CLK); chk("t2_wen", ramWEN, 1); chk("t2_addr", ramaddr, 32'h80);
    chk("t2_store", ramstore, 32'hCAFEF00D); chk("t2_dwait", dwait, 0);
    chk("t2_iwait", iwait, 1); chk("t2_ren", ramREN, 0);
    tick(); dWEN = 1'b0;
    for (int k = 0; k < IGAP; k++) begin
      @(negedge CLK); chk("t2_gap_ren", ramREN, 0); chk("t2_gap_iwait", iwait, 1);
      tick();
    end
    @(negedge CLK); chk("t2_iren", ramREN, 1); chk("t2_iaddr", ramaddr, 32'h200);
    chk("t2_iwait_lo", iwait, 0); chk("t2_iload", iload, 32'h11112222);
    tick(); iREN = 1'b0;
    settle(6);

    // Two-word dcache block with icache contending
`ifdef DBURST_LOCK_EN
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h300);
`else
    exp_q.push_back(32'h100); exp_q.push_back(32'h300); exp_q.push_back(32'h104);
`endif
    tick(); iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; dWEN = 1'b0; daddr = 32'h100;
    ramstate = ACCESS; ramload = 32'h0F0F0F0F; phase = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge CLK);
      dw = ~dwait; iw = ~iwait;
      if (dw || iw) chk("t3_order", ramaddr, exp_q.pop_front());
      tick();
      if (phase == 1) begin phase = 2; dREN = 1'b1; daddr = 32'h104; end
      if (dw && phase == 0) begin phase = 1; dREN = 1'b0; end
      else if (dw && phase == 2) begin phase = 3; dREN = 1'b0; end
      if (iw) iREN = 1'b0;
    end
    chk("t3_all_done", exp_q.size(), 0);
    exp_q.delete();
    settle(6);

    // Timeout with RAM stuck BUSY
    tick(); dREN = 1'b1; daddr = 32'h44; ramstate = BUSY;
    gcnt = 0; seen = 1'b0; got = '0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge CLK);
      if (ramREN) gcnt++;
      if (!dwait) begin seen = 1'b1; got = dload; end
      tick();
    end
    dREN = 1'b0;
    chk("t4_seen", seen, 1); chk("t4_cycles", gcnt, TO_CYC); chk("t4_dload", got, BAD);
    @(negedge CLK); chk("t4_merr", merr, 1);
    settle(3);
    @(negedge CLK); chk("t4_merr_sticky", merr, 1);

    // icache abandons mid-access
    tick(); iREN = 1'b1; iaddr = 32'h400; ramstate = BUSY;
    @(negedge CLK);
    tick();
    @(negedge CLK); chk("t5_ren", ramREN, 1);
    tick(); iREN = 1'b0;
    @(negedge CLK); chk("t5_drop_ren", ramREN, 0); chk("t5_drop_iwait", iwait, 1);
    tick();
    @(negedge CLK); chk("t5_idle", dbg_state, IDLE); chk("t5_iwait", iwait, 1);
    settle(2);

    // Asynchronous reset in the middle of a dcache grant
    tick(); dREN = 1'b1; daddr = 32'h48; ramstate = BUSY;
    @(negedge CLK);
    tick();
    @(negedge CLK); chk("t6_ren", ramREN, 1);
    #2 nRST = 1'b0;
    #1;
    chk("t6_async_ren", ramREN, 0); chk("t6_async_addr", ramaddr, 0);
    chk("t6_async_dwait", dwait, 1); chk("t6_async_dload", dload, 0);
    chk("t6_async_merr", merr, 0); chk("t6_async_state", dbg_state, IDLE);
    tick();
    @(negedge CLK);
    tick(); nRST = 1'b1; ramstate = ACCESS; ramload = 32'h5A5A1234;
    @(negedge CLK); chk("t6_post_idle", ramREN, 0);
    tick();
    @(negedge CLK); chk("t6_post_ren", ramREN, 1); chk("t6_post_addr", ramaddr, 32'h48);
    chk("t6_post_dwait", dwait, 0); chk("t6_post_dload", dload, 32'h5A5A1234);
    tick(); dREN = 1'b0;
    settle(6);

    // Random traffic checked by the model
    d_act = 1'b0; i_act = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      d_follow = m_d_done && !daddr[2] && ($urandom_range(0, 1) == 1);
      if (m_d_done || (d_act && $urandom_range(0, 39) == 0)) begin
        d_act = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      end
      if (d_follow || (!d_act && $urandom_range(0, 2) == 0)) begin
        if (d_follow) daddr = daddr | 32'h4;
        else daddr = 32'h1000 + ($urandom_range(0, 7) << 3) + ($urandom_range(0, 1) << 2);
        case ($urandom_range(0, 3))
          0:       begin dREN = 1'b0; dWEN = 1'b1; end
          1:       begin dREN = 1'b1; dWEN = 1'b1; end
          default: begin dREN = 1'b1; dWEN = 1'b0; end
        endcase
        dstore = $urandom;
        d_act  = 1'b1;
      end
      if (m_i_done || (i_act && $urandom_range(0, 49) == 0)) begin
        i_act = 1'b0; iREN = 1'b0;
      end
      if (!i_act && $urandom_range(0, 1) == 0) begin
        i_act = 1'b1; iREN = 1'b1; iaddr = 32'h8000 + ($urandom_range(0, 255) << 2);
      end
      case ($urandom_range(0, 19))
        0,1,2,3,4,5,6,7,8,9:   ramstate = ACCESS;
        10,11,12,13,14,15,16:  ramstate = BUSY;
        17:                    ramstate = ERROR;
        default:               ramstate = FREE;
      endcase
      ramload = $urandom;
    end
    settle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
